// File: rtl/turf_hdr_pkg.sv
// +----------------------------------------------------------------------+
// | turf_hdr_pkg : shared constants and types for the TURF header builder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package turf_hdr_pkg;

  localparam int         HDR_BEATS = 16;
  localparam logic [3:0] LAST_BEAT = 4'd15;

  localparam logic [3:0] BEAT_ID   = 4'd0;
  localparam logic [3:0] BEAT_TIME = 4'd1;
  localparam logic [3:0] BEAT_TRIG = 4'd2;
  localparam logic [3:0] BEAT_CNT  = 4'd3;

  // Trigger record layout
  localparam int TRIG_W   = 96;
  localparam int EVT_LSB  = 0;
  localparam int EVT_W    = 32;
  localparam int TS_LSB   = 32;
  localparam int TS_W     = 48;
  localparam int TYPE_LSB = 80;
  localparam int TYPE_W   = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } hdr_state_t;

endpackage

`default_nettype wire

// File: rtl/turf_hdr_csum.sv
// +----------------------------------------------------------------------+
// | turf_hdr_csum : XOR accumulator over header beats, clear has priority |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module turf_hdr_csum #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/turf_hdr_builder.sv
// +----------------------------------------------------------------------+
// | turf_hdr_builder : one trigger record in, one 16-beat TURF header out |
// | Optional beat-15 checksum: define TURF_HDR_CHECKSUM_EN               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module turf_hdr_builder
  import turf_hdr_pkg::*;
#(
  parameter logic [15:0] HDR_MAGIC   = 16'hDA7A,
  parameter logic [7:0]  HDR_VERSION = 8'h01
) (
  input  logic              memclk,
  input  logic              memresetn,
  input  logic [TRIG_W-1:0] s_trig_tdata,
  input  logic              s_trig_tvalid,
  output logic              s_trig_tready,
  input  logic [15:0]       run_number_i,
  input  logic [3:0]        tio_mask_i,
  output logic [63:0]       m_thdr_tdata,
  output logic              m_thdr_tvalid,
  input  logic              m_thdr_tready,
  output logic              m_thdr_tlast,
  output logic [31:0]       hdr_count_o
);

  hdr_state_t        r_state;
  hdr_state_t        w_state_nxt;
  logic [3:0]        r_beat;
  logic [EVT_W-1:0]  r_event;
  logic [TS_W-1:0]   r_tstamp;
  logic [TYPE_W-1:0] r_type;
  logic [15:0]       r_run;
  logic [3:0]        r_mask;
  logic [31:0]       r_cnt_snap;
  logic [31:0]       r_hdr_count;

  logic              w_accept;
  logic              w_beat_hs;
  logic              w_last_hs;
  logic [63:0]       w_beat_data;
  logic [63:0]       w_csum;

  // Handshake flags come only from registered state, so neither side sees the other combinationally.
  assign s_trig_tready = (r_state == ST_IDLE) && memresetn;
  assign m_thdr_tvalid = (r_state == ST_SEND);
  assign m_thdr_tlast  = m_thdr_tvalid && (r_beat == LAST_BEAT);
  assign m_thdr_tdata  = w_beat_data;
  assign hdr_count_o   = r_hdr_count;

  assign w_accept  = s_trig_tvalid && s_trig_tready;
  assign w_beat_hs = m_thdr_tvalid && m_thdr_tready;
  assign w_last_hs = w_beat_hs && (r_beat == LAST_BEAT);

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_SEND;
      ST_SEND: if (w_last_hs) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      r_beat      <= '0;
      r_event     <= '0;
      r_tstamp    <= '0;
      r_type      <= '0;
      r_run       <= '0;
      r_mask      <= '0;
      r_cnt_snap  <= '0;
      r_hdr_count <= '0;
    end else begin
      if (w_accept) begin
        r_beat     <= '0;
        r_event    <= s_trig_tdata[EVT_LSB +: EVT_W];
        r_tstamp   <= s_trig_tdata[TS_LSB +: TS_W];
        r_type     <= s_trig_tdata[TYPE_LSB +: TYPE_W];
        r_run      <= run_number_i;
        r_mask     <= tio_mask_i;
        r_cnt_snap <= r_hdr_count;
      end else if (w_beat_hs) begin
        r_beat <= r_beat + 4'd1;
      end
      if (w_last_hs) begin
        r_hdr_count <= r_hdr_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_beat_data = '0;
    case (r_beat)
      BEAT_ID:   w_beat_data = {HDR_MAGIC, HDR_VERSION, 4'b0000, r_mask, r_event};
      BEAT_TIME: w_beat_data = {16'h0000, r_tstamp};
      BEAT_TRIG: w_beat_data = {32'h0000_0000, r_run, r_type};
      BEAT_CNT:  w_beat_data = {32'h0000_0000, r_cnt_snap};
      LAST_BEAT: w_beat_data = w_csum;
      default:   w_beat_data = '0;
    endcase
  end

`ifdef TURF_HDR_CHECKSUM_EN
  // Beat 15 is excluded so the accumulator already holds the final word while it is presented.
  turf_hdr_csum #(
    .DATA_W (64)
  ) u_csum (
    .clk    (memclk),
    .rst_n  (memresetn),
    .i_clr  (w_accept),
    .i_en   (w_beat_hs && (r_beat != LAST_BEAT)),
    .i_data (w_beat_data),
    .o_acc  (w_csum)
  );
`else
  assign w_csum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_turf_hdr_builder.sv
// +----------------------------------------------------------------------+
// | tb_turf_hdr_builder : randomized scoreboard bench for turf_hdr_builder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_turf_hdr_builder;

  logic        memclk = 1'b0;
  logic        memresetn = 1'b0;
  logic [95:0] s_trig_tdata = '0;
  logic        s_trig_tvalid = 1'b0;
  logic        s_trig_tready;
  logic [15:0] run_number_i = '0;
  logic [3:0]  tio_mask_i = '0;
  logic [63:0] m_thdr_tdata;
  logic        m_thdr_tvalid;
  logic        m_thdr_tready = 1'b0;
  logic        m_thdr_tlast;
  logic [31:0] hdr_count_o;

  always #5 memclk = ~memclk;

  turf_hdr_builder dut (
    .memclk        (memclk),
    .memresetn     (memresetn),
    .s_trig_tdata  (s_trig_tdata),
    .s_trig_tvalid (s_trig_tvalid),
    .s_trig_tready (s_trig_tready),
    .run_number_i  (run_number_i),
    .tio_mask_i    (tio_mask_i),
    .m_thdr_tdata  (m_thdr_tdata),
    .m_thdr_tvalid (m_thdr_tvalid),
    .m_thdr_tready (m_thdr_tready),
    .m_thdr_tlast  (m_thdr_tlast),
    .hdr_count_o   (hdr_count_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [64:0] exp_q[$];          // {tlast, tdata}
  logic [31:0] model_cnt = '0;    // headers the model expects to have been sent
  int          cyc = 0;
  bit          bp_en = 1'b0;
  bit          gap_chk = 1'b0;
  int          acc_cyc = -10;
  int          tlast_cyc = -10;

  always @(posedge memclk) cyc <= cyc + 1;

  always @(posedge memclk) begin
    #1;
    m_thdr_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference header: fields placed by the documented beat layout, checksum = XOR of beats 0..14.
  task automatic push_model(input logic [31:0] ev, input logic [47:0] ts, input logic [15:0] ty,
                            input logic [15:0] run, input logic [3:0] mask, input logic [31:0] cnt);
    logic [63:0] b [16];
    foreach (b[i]) b[i] = '0;
    b[0] = {16'hDA7A, 8'h01, 4'h0, mask, ev};
    b[1] = {16'h0000, ts};
    b[2] = {32'h0, run, ty};
    b[3] = {32'h0, cnt};
`ifdef TURF_HDR_CHECKSUM_EN
    for (int i = 0; i < 15; i++) b[15] ^= b[i];
`endif
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), b[i]});
  endtask

  task automatic push_literal_rec();
    exp_q.push_back({1'b0, 64'hDA7A010200000005});
    exp_q.push_back({1'b0, 64'h0000123456789ABC});
    exp_q.push_back({1'b0, 64'h0000000000420003});
    for (int i = 3; i < 15; i++) exp_q.push_back({1'b0, 64'h0});
`ifdef TURF_HDR_CHECKSUM_EN
    exp_q.push_back({1'b1, 64'hDA7A1336563A9ABA});
`else
    exp_q.push_back({1'b1, 64'h0});
`endif
  endtask

  // Presents one record, pushes its expected header, returns #1 after the accepting edge.
  task automatic send_rec(input logic [31:0] ev, input logic [47:0] ts, input logic [15:0] ty,
                          input logic [15:0] run, input logic [3:0] mask,
                          input bit chg_run, input bit literal);
    int k;
    s_trig_tdata  = {ty, ts, ev};
    run_number_i  = run;
    tio_mask_i    = mask;
    s_trig_tvalid = 1'b1;
    if (literal) push_literal_rec();
    else         push_model(ev, ts, ty, run, mask, model_cnt);
    model_cnt = model_cnt + 32'd1;
    for (k = 0; k < 200; k++) begin
      @(negedge memclk);
      if (s_trig_tready) break;
    end
    if (k == 200) fail_now("accept_timeout");
    @(posedge memclk);
    #1;
    s_trig_tvalid = 1'b0;
    if (chg_run) run_number_i = ~run;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge memclk);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    repeat (3) @(posedge memclk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks protocol rules.
  bit          prev_v = 1'b0;
  bit          hold_pend = 1'b0;
  logic [64:0] held = '0;
  always @(negedge memclk) begin
    logic [64:0] e;
    if (!memresetn) begin
      prev_v    = 1'b0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check("hold_stable", {m_thdr_tvalid, m_thdr_tlast, m_thdr_tdata}, {1'b1, held});
      hold_pend = 1'b0;
      if (s_trig_tvalid && s_trig_tready) begin
        if (gap_chk) begin
          check("b2b_accept_gap", 96'(cyc), 96'(tlast_cyc + 1));
          gap_chk = 1'b0;
        end
        acc_cyc = cyc;
      end
      if (m_thdr_tvalid) begin
        check("trig_ready_low_in_send", 96'(s_trig_tready), 96'(0));
        if (!prev_v) check("valid_latency", 96'(cyc), 96'(acc_cyc + 1));
        if (m_thdr_tready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = exp_q.pop_front();
            check("beat", {m_thdr_tlast, m_thdr_tdata}, e);
          end
          if (m_thdr_tlast) tlast_cyc = cyc;
        end else begin
          hold_pend = 1'b1;
          held      = {m_thdr_tlast, m_thdr_tdata};
        end
      end
      prev_v = m_thdr_tvalid;
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge memclk);
    #1;
    check("rst_trig_tready", 96'(s_trig_tready), 96'(0));
    check("rst_tvalid", 96'(m_thdr_tvalid), 96'(0));
    check("rst_tlast", 96'(m_thdr_tlast), 96'(0));
    check("rst_count", 96'(hdr_count_o), 96'(0));
    memresetn = 1'b1;
    @(posedge memclk);
    #1;

    // Known record, no backpressure
    bp_en = 1'b0;
    send_rec(32'h5, 48'h123456789ABC, 16'h3, 16'h42, 4'b0010, 1'b0, 1'b1);
    drain();
    check("count_after_first", 96'(hdr_count_o), 96'(1));

    // Same record with random backpressure
    bp_en = 1'b1;
    send_rec(32'h5, 48'h123456789ABC, 16'h3, 16'h42, 4'b0010, 1'b0, 1'b0);
    drain();
    check("count_after_bp", 96'(hdr_count_o), 96'(2));

    // Back-to-back records, second held valid through the first packet
    bp_en = 1'b0;
    send_rec($urandom, {$urandom, $urandom}, 16'($urandom), 16'h0100, 4'hF, 1'b0, 1'b0);
    gap_chk = 1'b1;
    send_rec($urandom, {$urandom, $urandom}, 16'($urandom), 16'h0101, 4'h1, 1'b0, 1'b0);
    drain();
    check("count_after_b2b", 96'(hdr_count_o), 96'(model_cnt));
    check("b2b_gap_checked", 96'(gap_chk), 96'(0));

    // Randomized records, backpressure, run number changed after accept on some
    bp_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      send_rec($urandom, {$urandom, $urandom}, 16'($urandom), 16'($urandom),
               4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge memclk);
      #1;
    end
    drain();
    check("count_after_random", 96'(hdr_count_o), 96'(model_cnt));

    // Reset in the middle of a packet (beat 7 on the bus)
    bp_en = 1'b0;
    @(posedge memclk);
    #1;
    send_rec($urandom, {$urandom, $urandom}, 16'($urandom), 16'($urandom), 4'h5, 1'b0, 1'b0);
    repeat (7) @(posedge memclk);
    #2;
    memresetn = 1'b0;
    #1;
    check("abort_tvalid", 96'(m_thdr_tvalid), 96'(0));
    check("abort_tlast", 96'(m_thdr_tlast), 96'(0));
    check("abort_trig_tready", 96'(s_trig_tready), 96'(0));
    check("abort_count", 96'(hdr_count_o), 96'(0));
    exp_q.delete();
    model_cnt = '0;
    repeat (2) @(posedge memclk);
    #1;
    memresetn = 1'b1;
    @(posedge memclk);
    #1;
    check("post_reset_count", 96'(hdr_count_o), 96'(0));
    send_rec(32'hCAFE0001, 48'h0000_1111_2222, 16'h00AA, 16'h0007, 4'h8, 1'b1, 1'b0);
    drain();
    check("post_reset_count_1", 96'(hdr_count_o), 96'(1));

    // Header counter wrap
    force dut.r_hdr_count = 32'hFFFF_FFFF;
    @(posedge memclk);
    #1;
    release dut.r_hdr_count;
    @(posedge memclk);
    #1;
    check("preload_count", 96'(hdr_count_o), 96'(32'hFFFF_FFFF));
    model_cnt = 32'hFFFF_FFFF;
    bp_en = 1'b1;
    send_rec($urandom, {$urandom, $urandom}, 16'($urandom), 16'($urandom), 4'h3, 1'b0, 1'b0);
    drain();
    check("count_wrap", 96'(hdr_count_o), 96'(0));
    check("scoreboard_empty", 96'(exp_q.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/turf_hdr_builder.md
Name: turf_hdr_builder

Overview:
- Builds the fixed 16-beat (128-byte) TURF event header that feeds the header accumulator's TURF-header input.
- Accepts one trigger record per event in the memclk domain.
- Emits one 64-bit AXI4-Stream packet per record, with tlast on beat 15.
- Has no internal FIFO: at most one record is in flight, and the trigger source is backpressured while a header is being sent.

Parameters:
- HDR_MAGIC, 16'hDA7A, magic placed in beat 0 bits [63:48]
- HDR_VERSION, 8'h01, header format version placed in beat 0 bits [47:40]

Ports:
- memclk  in  1  clock; all logic in this domain
- memresetn  in  1  asynchronous, active-low reset
- s_trig_tdata  in  96  trigger record: [31:0] event number, [79:32] 48-bit timestamp, [95:80] trigger type
- s_trig_tvalid  in  1  record valid
- s_trig_tready  out  1  record accepted
- run_number_i  in  16  current run number, quasi-static, sampled at accept
- tio_mask_i  in  4  TURFIO mask (memclk copy), sampled at accept
- m_thdr_tdata  out  64  header beat
- m_thdr_tvalid  out  1  beat valid
- m_thdr_tready  in  1  downstream ready
- m_thdr_tlast  out  1  high on beat 15 only
- hdr_count_o  out  32  headers fully sent since reset

Behaviour:
- Reset (async assert, sync release): state IDLE, beat counter 0, all capture registers 0, checksum accumulator 0, hdr_count_o 0. s_trig_tready, m_thdr_tvalid and m_thdr_tlast are 0 while in reset.
- FSM has two states, IDLE and SEND.
- IDLE:
  - s_trig_tready = 1.
  - On s_trig_tvalid, capture event, timestamp, type, run_number_i, tio_mask_i and current hdr_count_o.
  - Clear checksum accumulator and beat counter; go to SEND.
  - m_thdr_tvalid rises on the cycle after accept (latency 1).
- SEND:
  - s_trig_tready = 0, m_thdr_tvalid = 1.
  - Beat counter (4 bits) selects data; it advances on tvalid&&tready.
  - tdata and tlast hold stable while tready is low.
- Beat layout:
  - beat 0 = {HDR_MAGIC, HDR_VERSION, 4'b0, tio_mask, event[31:0]}
  - beat 1 = {16'h0, timestamp[47:0]}
  - beat 2 = {32'h0, run_number[15:0], trig_type[15:0]}
  - beat 3 = {32'h0, captured hdr_count}
  - beats 4–14 = 0 (reserved)
  - beat 15 = checksum word (see Optional Feature)
- On the beat-15 handshake:
  - hdr_count_o increments, wrapping 2^32-1 → 0.
  - Return to IDLE.
  - The next record can be accepted on the following cycle, so the minimum packet spacing is 17 cycles.
- A record held valid during SEND is not accepted until IDLE; its tdata must be held by the source per AXI4-S.
- Reset asserted mid-packet aborts it immediately. No tlast is emitted and hdr_count_o is not incremented; downstream must also be reset.
- No combinational path from m_thdr_tready to s_trig_tready, or from s_trig_tvalid to m_thdr_tvalid.

Optional Feature:
- Macro: TURF_HDR_CHECKSUM_EN.
- Defined: the accumulator XORs each beat 0–14 as it is handshaken, and beat 15 = the accumulator value.
- Undefined: beat 15 = 64'h0, and no accumulator logic is instantiated.

Decomposition:
- Package turf_hdr_pkg holds:
  - HDR_BEATS=16 and LAST_BEAT=4'd15
  - beat index constants BEAT_ID=0, BEAT_TIME=1, BEAT_TRIG=2, BEAT_CNT=3
  - trigger-record field offsets/widths
  - the state enum type
- One natural sub-module, turf_hdr_csum: XOR accumulator with clear/enable, only instantiated under TURF_HDR_CHECKSUM_EN.

Test Plan:
- Single record: event 0x00000005, timestamp 0x123456789ABC, type 0x0003, run 0x0042, mask 4'b0010, tready=1 → exactly 16 beats:
  - beat0 0xDA7A010200000005, beat1 0x0000123456789ABC, beat2 0x0000000000420003, beat3 0
  - beat15 0xDA7A1336563A9ABA (with _EN) or 0 (without)
  - tlast on beat 15 only; hdr_count_o=1 afterwards.
- Random tready backpressure (50%) on the same record → identical beat sequence; tdata/tlast stable whenever tvalid&&!tready.
- Two back-to-back records (second tvalid held high) → second accepted exactly 1 cycle after the first's tlast handshake; its beat3 = 1; s_trig_tready low throughout the first packet.
- Preload hdr_count to 0xFFFFFFFF (force or 2^32 run in formal) → next header's beat3 = 0xFFFFFFFF, hdr_count_o wraps to 0.
- Assert memresetn low at beat 7 with tready=1 → outputs drop to 0 asynchronously; after release, a new record produces a full 16-beat packet starting at beat0, and hdr_count_o=0.
- run_number_i changed on the cycle after accept → beat2 still carries the value sampled at accept.
